// File: rtl/dmem_bus_bridge_pkg.sv
// Shared constants and helpers for the MEM-stage data-bus bridge.
// Access-size decode, byte enables, lane replication, alignment check.
package dmem_bus_bridge_pkg;

    localparam logic [2:0] BT_B  = 3'b000;
    localparam logic [2:0] BT_H  = 3'b001;
    localparam logic [2:0] BT_W  = 3'b010;
    localparam logic [2:0] BT_BU = 3'b100;
    localparam logic [2:0] BT_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_WAIT_R = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int TIMEOUT_CYCLES_DEF = 255;

    // bit1 set covers W plus the 011/110/111 encodings
    function automatic logic is_word(input logic [2:0] bt);
        return bt[1];
    endfunction

    function automatic logic is_half(input logic [2:0] bt);
        return !bt[1] && bt[0];
    endfunction

    function automatic logic misaligned(input logic [2:0] bt,
                                        input logic [1:0] a);
        logic m;
        m = 1'b0;
        if (is_word(bt))
            m = |a;
        else if (is_half(bt))
            m = a[0];
        return m;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] bt,
                                           input logic [1:0] a);
        logic [3:0] be;
        if (is_word(bt))
            be = 4'b1111;
        else if (is_half(bt))
            be = 4'b0011 << a;
        else
            be = 4'b0001 << a;
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0]  bt,
                                               input logic [31:0] w);
        logic [31:0] d;
        if (is_word(bt))
            d = w;
        else if (is_half(bt))
            d = {2{w[15:0]}};
        else
            d = {4{w[7:0]}};
        return d;
    endfunction

endpackage

// File: rtl/dmem_bus_bridge_load_align_ext.sv
// Load lane select and sign/zero extension, purely combinational.
// Shared by the bus bridge and any future cache fill path.
module load_align_ext
    import dmem_bus_bridge_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  byt_typ,
    output logic [31:0] ext
);

    logic [31:0] sh;
    logic        sgn;

    // shift the addressed lane down to bit 0, then extend it
    always_comb begin
        sh  = rdata >> {addr, 3'b000};
        sgn = !byt_typ[2];
        if (is_word(byt_typ))
            ext = rdata;
        else if (is_half(byt_typ))
            ext = {{16{sgn & sh[15]}}, sh[15:0]};
        else
            ext = {{24{sgn & sh[7]}}, sh[7:0]};
    end

endmodule

// File: rtl/dmem_bus_bridge.sv
// MEM-stage to req/gnt/rvalid data-bus bridge with pipeline stall.
// Optional watchdog enabled by defining BUS_TIMEOUT_EN.
module dmem_bus_bridge
    import dmem_bus_bridge_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int WORD_W         = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [2:0]        req_byt_typ,
    output logic              stall,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              misalign_err,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [WORD_W-1:0] bus_rdata
);

    logic [1:0]        state_q, state_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        bt_q, bt_d;
    logic [3:0]        be_q, be_d;
    logic [WORD_W-1:0] wd_q, wd_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] ext_word;
    logic              stall_c, mis_c;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = 16;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo;
    assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    load_align_ext u_ext (
        .rdata   (bus_rdata),
        .addr    (addr_q[1:0]),
        .byt_typ (bt_q),
        .ext     (ext_word)
    );

    // next-state, capture and stall decode
    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        bt_d    = bt_q;
        be_d    = be_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        stall_c = 1'b0;
        mis_c   = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (misaligned(req_byt_typ, req_addr[1:0])) begin
                        mis_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = ST_REQ;
                        wen_d   = req_wen;
                        addr_d  = req_addr;
                        bt_d    = req_byt_typ;
                        be_d    = byte_en(req_byt_typ, req_addr[1:0]);
                        wd_d    = lane_wdata(req_byt_typ, req_wdata);
                        err_d   = 1'b0;
`ifdef BUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ST_REQ: begin
                stall_c = 1'b1;
`ifdef BUS_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (bus_gnt) begin
                    state_d = wen_q ? ST_DONE : ST_WAIT_R;
`ifdef BUS_TIMEOUT_EN
                    cnt_d = '0;
                end else if (tmo) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (!wen_q)
                        rdata_d = '0;
`endif
                end
            end
            ST_WAIT_R: begin
                stall_c = 1'b1;
`ifdef BUS_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (bus_rvalid) begin
                    rdata_d = ext_word;
                    state_d = ST_DONE;
`ifdef BUS_TIMEOUT_EN
                end else if (tmo) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and captured-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            bt_q    <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            bt_q    <= bt_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    // watchdog counter for REQ / WAIT_R residency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
    assign bus_err = (state_q == ST_DONE) && err_q;
`else
    assign bus_err = 1'b0;
`endif

    // comb outputs are forced low while reset is held
    assign stall        = stall_c & rst_n;
    assign misalign_err = mis_c & rst_n;

    assign bus_req   = (state_q == ST_REQ);
    assign bus_we    = wen_q;
    assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_be    = be_q;
    assign bus_wdata = wd_q;
    assign rsp_valid = (state_q == ST_DONE) && !wen_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the MEM stage.
- Converts the MEM stage's single-cycle load/store request into a req/gnt/rvalid external data-bus transaction.
- Stalls the pipeline while the transaction is outstanding, then returns aligned, sign/zero-extended load data.
- Generates byte enables and lane-replicated write data; flags misaligned accesses.

Parameters:
- ADDR_W, 32, byte address width (matches MEM_ADDR_WIDTH)
- WORD_W, 32, data word width (fixed 32; byte enables are 4 bits)
- TIMEOUT_CYCLES, 255, watchdog limit (used only with BUS_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM stage has a load/store this cycle; held stable while stall=1
- req_wen  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  WORD_W  store data (rs2 value)
- req_byt_typ  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- stall  out  1  freeze the pipeline upstream of WB
- rsp_valid  out  1  one-cycle pulse: load data valid
- rsp_rdata  out  WORD_W  extended load result
- misalign_err  out  1  one-cycle pulse: request dropped
- bus_err  out  1  one-cycle pulse: timeout (0 without macro)
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  word-aligned address, addr[1:0]=00
- bus_be  out  4  byte enables
- bus_wdata  out  WORD_W  lane-replicated write data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  WORD_W  read word

Behaviour:
- Reset: FSM=IDLE; all outputs 0; captured registers 0. Asserting rst_n mid-transaction drops bus_req immediately; the in-flight transaction is abandoned.
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - req_valid and aligned: capture addr/wen/byt_typ/wdata, go to REQ. stall=1 combinationally this cycle.
  - req_valid and misaligned: misalign_err=1, stall=0, no bus activity, stay in IDLE.
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0. Encodings 011, 110 and 111 are treated as W.
- REQ: bus_req=1 with registered bus_we/addr/be/wdata, all stable until bus_gnt.
  - gnt and write: go to DONE.
  - gnt and read: go to WAIT_R.
  - bus_rvalid is ignored in REQ.
- WAIT_R: bus_req=0. On bus_rvalid, register the extended data and go to DONE.
- DONE:
  - stall=0; rsp_valid=1 only for loads; rsp_rdata holds the value.
  - req_valid in DONE is the already-served request and is ignored.
  - Always returns to IDLE.
  - rsp_rdata holds its value until the next load completes.
- stall = (IDLE & req_valid & aligned) | REQ | WAIT_R.
- Minimum latency, counted from the accept cycle (0), assuming immediate gnt:
  - store: DONE at cycle 2
  - load with rvalid the cycle after gnt: DONE at cycle 3
- Byte enables:
  - B: 4'b0001<<addr[1:0]
  - H: 4'b0011<<addr[1:0]
  - W: 4'b1111
- Write data: B replicates the byte 4x; H replicates the halfword 2x; W passes through.
- Load extraction: select the lane by captured addr[1:0]. B/H sign-extend bit 7/15; BU/HU zero-extend.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro:
  - 8..16-bit counter clears on entry to REQ or WAIT_R and increments each cycle in those states.
  - On reaching TIMEOUT_CYCLES: bus_req drops, go to DONE. bus_err=1 for that DONE cycle; loads return rsp_valid=1 with rsp_rdata=0.
- Without the macro: no counter; bus_err tied 0; transactions wait indefinitely.

Decomposition:
- constants.vh additions: byt_typ encodings (BT_B, BT_H, BT_W, BT_BU, BT_HU); FSM state encodings (2-bit); default TIMEOUT_CYCLES.
- Sub-module load_align_ext: combinational; inputs rdata, addr[1:0], byt_typ; output extended word. Reusable by any future cache fill path.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt in the first REQ cycle -> bus_addr=0x100, be=1111, wdata=0xDEADBEEF; stall high 2 cycles, low in DONE; rsp_valid never asserted.
- SB addr 0x203, data 0x000000A5 -> bus_addr=0x200, be=1000, wdata=0xA5A5A5A5.
- LB addr 0x102, rdata 0x00800000 -> rsp_rdata=0xFFFFFF80. Same access as LBU -> 0x00000080. LH addr 0x102, rdata 0x80010000 -> 0xFFFF8001.
- LW addr 0x101 -> misalign_err pulse 1 cycle, stall=0, bus_req never asserted.
- Load with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> bus signals stable through the wait; stall high through WAIT_R; rsp_valid exactly 1 cycle; no re-issue in the following IDLE cycle.
- rst_n low while in WAIT_R -> bus_req/stall/rsp_valid go 0 immediately, FSM=IDLE. With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4 and gnt never given -> bus_err and rsp_valid pulse with rdata=0 at cycle 5.
